// File: rtl/apb_cmd_slave_if.sv
// APB4 bus plus AXI-Lite engine command/response signals for apb_cmd_slave.
// The slave modport is the bridge front end; the master modport is its environment.
interface apb_cmd_slave_if #(
    parameter int unsigned AW_APB = 32,
    parameter int unsigned DW_APB = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [AW_APB-1:0]     paddr;
    logic [DW_APB-1:0]     pwdata;
    logic [2:0]            pprot;
    logic [DW_APB/8-1:0]   pstrb;
    logic                  pready;
    logic [DW_APB-1:0]     prdata;
    logic                  pslverr;

    logic                  start_write;
    logic                  start_read;
    logic [AW_APB-1:0]     address;
    logic [DW_APB-1:0]     write_data;
    logic [2:0]            prot;
    logic [DW_APB/8-1:0]   be;
    logic [1:0]            resp;
    logic [DW_APB-1:0]     read_data;
    logic                  read_data_valid;
    logic                  done_write;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pprot, pstrb,
        output pready, prdata, pslverr,
        output start_write, start_read, address, write_data, prot, be,
        input  resp, read_data, read_data_valid, done_write
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pprot, pstrb,
        input  pready, prdata, pslverr,
        input  start_write, start_read, address, write_data, prot, be,
        output resp, read_data, read_data_valid, done_write
    );
endinterface

// File: rtl/apb_cmd_slave.sv
// APB4 slave front end: turns each APB transfer into a one-cycle AXI-Lite engine command.
// Define APB_TIMEOUT_EN to add a response watchdog that absorbs the late (orphan) response.
module apb_cmd_slave #(
    parameter int unsigned AW_APB         = 32,
    parameter int unsigned DW_APB         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic            axi_clk,
    input logic            sys_areset,
    apb_cmd_slave_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StDone} state_e;

    state_e              state_q, state_d;
    logic [AW_APB-1:0]   address_q, address_d;
    logic [DW_APB-1:0]   write_data_q, write_data_d;
    logic [2:0]          prot_q, prot_d;
    logic [DW_APB/8-1:0] be_q, be_d;
    logic                is_write_q, is_write_d;
    logic [DW_APB-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic                start_write_q, start_write_d;
    logic                start_read_q, start_read_d;

    logic resp_hit;
    logic busy_orphan;
    logic timeout_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // Only the completion pulse matching the outstanding command type counts.
    assign resp_hit = is_write_q ? bus.done_write : bus.read_data_valid;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            orphan_q, orphan_d;

    // Any completion pulse while an orphan is pending belongs to the abandoned command.
    assign busy_orphan = orphan_q & ~(bus.done_write | bus.read_data_valid);
    assign timeout_hit = (state_q == StWaitResp) && !resp_hit &&
                         (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIssue) begin
            cnt_d = '0;
        end else if (state_q == StWaitResp) begin
            cnt_d = cnt_q + 1'b1;
        end
        orphan_d = busy_orphan | timeout_hit;
    end

    always_ff @(posedge axi_clk or posedge sys_areset) begin
        if (sys_areset) begin
            cnt_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
        end
    end
`else
    assign busy_orphan = 1'b0;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        write_data_d  = write_data_q;
        prot_d        = prot_q;
        be_d          = be_q;
        is_write_d    = is_write_q;
        prdata_d      = prdata_q;
        pready_d      = 1'b0;
        pslverr_d     = 1'b0;
        start_write_d = 1'b0;
        start_read_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.psel && !bus.penable) begin
                    address_d    = bus.paddr;
                    write_data_d = bus.pwdata;
                    prot_d       = bus.pprot;
                    be_d         = bus.pwrite ? bus.pstrb : '0;
                    is_write_d   = bus.pwrite;
                    state_d      = StIssue;
                    if (!busy_orphan) begin
                        start_write_d = bus.pwrite;
                        start_read_d  = !bus.pwrite;
                    end
                end
            end
            StIssue: begin
                // Stay here without a pulse while an orphan response is still owed.
                if (start_write_q || start_read_q) begin
                    state_d = StWaitResp;
                end else if (!busy_orphan) begin
                    start_write_d = is_write_q;
                    start_read_d  = !is_write_q;
                end
            end
            StWaitResp: begin
                if (resp_hit) begin
                    state_d   = StDone;
                    pready_d  = 1'b1;
                    pslverr_d = (bus.resp == 2'b10) || (bus.resp == 2'b11);
                    prdata_d  = is_write_q ? '0 : bus.read_data;
                end else if (timeout_hit) begin
                    state_d   = StDone;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge axi_clk or posedge sys_areset) begin
        if (sys_areset) begin
            state_q       <= StIdle;
            address_q     <= '0;
            write_data_q  <= '0;
            prot_q        <= '0;
            be_q          <= '0;
            is_write_q    <= 1'b0;
            prdata_q      <= '0;
            pready_q      <= 1'b0;
            pslverr_q     <= 1'b0;
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            write_data_q  <= write_data_d;
            prot_q        <= prot_d;
            be_q          <= be_d;
            is_write_q    <= is_write_d;
            prdata_q      <= prdata_d;
            pready_q      <= pready_d;
            pslverr_q     <= pslverr_d;
            start_write_q <= start_write_d;
            start_read_q  <= start_read_d;
        end
    end

    assign bus.pready      = pready_q;
    assign bus.prdata      = prdata_q;
    assign bus.pslverr     = pslverr_q;
    assign bus.start_write = start_write_q;
    assign bus.start_read  = start_read_q;
    assign bus.address     = address_q;
    assign bus.write_data  = write_data_q;
    assign bus.prot        = prot_q;
    assign bus.be          = be_q;
endmodule

// File: tb/tb_apb_cmd_slave.sv
// Self-checking bench for apb_cmd_slave: per-cycle expectation tables built from transfer timing
// rules, checked every cycle, plus literal checks on captured command/response values.
module tb_apb_cmd_slave;
    localparam int TOUT   = 16;
    localparam int MaxCyc = 1024;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    apb_cmd_slave_if #(.AW_APB(32), .DW_APB(32)) bus_if ();

    apb_cmd_slave #(
        .AW_APB         (32),
        .DW_APB         (32),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .axi_clk    (clk),
        .sys_areset (rst),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle; everything not set is expected low.
    bit        exp_sw     [MaxCyc];
    bit        exp_sr     [MaxCyc];
    bit [31:0] exp_addr   [MaxCyc];
    bit [31:0] exp_wdata  [MaxCyc];
    bit [2:0]  exp_prot   [MaxCyc];
    bit [3:0]  exp_be     [MaxCyc];
    bit        exp_pready [MaxCyc];
    bit        exp_err    [MaxCyc];
    bit [31:0] exp_rdata  [MaxCyc];

    int          n_start = 0;
    int          n_pready = 0;
    logic [31:0] seen_addr, seen_wdata, seen_prdata;
    logic [3:0]  seen_be;
    logic [2:0]  seen_prot;
    logic        seen_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < MaxCyc) begin
            chk("start_write", 32'(bus_if.start_write), 32'(exp_sw[cyc]));
            chk("start_read", 32'(bus_if.start_read), 32'(exp_sr[cyc]));
            chk("pready", 32'(bus_if.pready), 32'(exp_pready[cyc]));
            chk("pslverr", 32'(bus_if.pslverr), 32'(exp_err[cyc]));
            if (exp_sw[cyc] || exp_sr[cyc]) begin
                chk("address", bus_if.address, exp_addr[cyc]);
                chk("write_data", bus_if.write_data, exp_wdata[cyc]);
                chk("prot", 32'(bus_if.prot), 32'(exp_prot[cyc]));
                chk("be", 32'(bus_if.be), 32'(exp_be[cyc]));
            end
            if (exp_pready[cyc]) chk("prdata", bus_if.prdata, exp_rdata[cyc]);
        end
        if (bus_if.start_write === 1'b1 || bus_if.start_read === 1'b1) begin
            n_start++;
            seen_addr  = bus_if.address;
            seen_wdata = bus_if.write_data;
            seen_be    = bus_if.be;
            seen_prot  = bus_if.prot;
        end
        if (bus_if.pready === 1'b1) begin
            n_pready++;
            seen_prdata = bus_if.prdata;
            seen_err    = bus_if.pslverr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.psel            = 1'b0;
        bus_if.penable         = 1'b0;
        bus_if.done_write      = 1'b0;
        bus_if.read_data_valid = 1'b0;
        bus_if.resp            = 2'b00;
        bus_if.read_data       = 32'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pready"}, 32'(bus_if.pready), 32'h0);
        chk({tag, "_pslverr"}, 32'(bus_if.pslverr), 32'h0);
        chk({tag, "_start"}, 32'({bus_if.start_write, bus_if.start_read}), 32'h0);
        chk({tag, "_prdata"}, bus_if.prdata, 32'h0);
        chk({tag, "_address"}, bus_if.address, 32'h0);
        chk({tag, "_wdata"}, bus_if.write_data, 32'h0);
        chk({tag, "_prot_be"}, 32'({bus_if.prot, bus_if.be}), 32'h0);
    endtask

    task automatic expect_start(input int st, input bit wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                input logic [2:0] pr);
        exp_sw[st]    = wr;
        exp_sr[st]    = !wr;
        exp_addr[st]  = addr;
        exp_wdata[st] = data;
        exp_prot[st]  = pr;
        exp_be[st]    = wr ? strb : 4'h0;
    endtask

    // One APB transfer starting with its setup phase in the current cycle.
    // lat: completion pulse this many cycles after the start pulse (0 = never answer).
    // late: cycle offset of an orphan read_data_valid that must be absorbed before the command.
    // wrong: send a completion of the wrong type in the first wait cycle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] pr, input int lat,
                        input logic [1:0] rsp, input logic [31:0] rdata, input int late,
                        input bit wrong);
        int s, st, cmp, dn;
        s   = cyc;
        st  = (late > 0) ? s + late + 1 : s + 1;
        cmp = (lat > 0) ? st + lat : -1;
        dn  = (lat > 0) ? cmp + 1 : st + 1 + TOUT;
        expect_start(st, wr, addr, data, strb, pr);
        exp_pready[dn] = 1'b1;
        exp_err[dn]    = (lat > 0) ? rsp[1] : 1'b1;
        exp_rdata[dn]  = (lat > 0 && !wr) ? rdata : 32'h0;
        bus_if.pwrite = wr;
        bus_if.paddr  = addr;
        bus_if.pwdata = data;
        bus_if.pstrb  = strb;
        bus_if.pprot  = pr;
        for (int c = s; c <= dn; c++) begin
            bus_if.psel            = 1'b1;
            bus_if.penable         = (c > s);
            bus_if.done_write      = (wr && c == cmp) || (wrong && !wr && c == st + 1);
            bus_if.read_data_valid = (!wr && c == cmp) || (late > 0 && c == s + late) ||
                                     (wrong && wr && c == st + 1);
            bus_if.resp            = (c == cmp) ? rsp : 2'b11;
            bus_if.read_data       = (c == cmp) ? rdata : 32'hBAD0BAD0;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int n0, n1, s;
        rst = 1'b1;
        idle_inputs();
        bus_if.pwrite = 1'b0;
        bus_if.paddr  = 32'h0;
        bus_if.pwdata = 32'h0;
        bus_if.pstrb  = 4'h0;
        bus_if.pprot  = 3'b000;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Basic write, response three cycles after the start pulse.
        n0 = n_start;
        xfer(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 3'b010, 3, 2'b00, 32'h0, 0, 1'b0);
        chk("wr_nstart", n_start - n0, 32'd1);
        chk("wr_addr", seen_addr, 32'h40);
        chk("wr_wdata", seen_wdata, 32'hDEADBEEF);
        chk("wr_be", 32'(seen_be), 32'hF);
        chk("wr_prot", 32'(seen_prot), 32'h2);
        chk("wr_err", 32'(seen_err), 32'h0);

        // Read with a stray done_write during the wait, which must be ignored.
        xfer(1'b0, 32'h44, 32'h0BADF00D, 4'hF, 3'b000, 3, 2'b00, 32'h12345678, 0, 1'b1);
        chk("rd_addr", seen_addr, 32'h44);
        chk("rd_be", 32'(seen_be), 32'h0);
        chk("rd_prdata", seen_prdata, 32'h12345678);
        chk("rd_err", 32'(seen_err), 32'h0);

        // Error responses.
        xfer(1'b0, 32'h48, 32'h0, 4'h0, 3'b001, 1, 2'b10, 32'hCAFEF00D, 0, 1'b0);
        chk("slverr_rd", 32'(seen_err), 32'h1);
        chk("slverr_rd_data", seen_prdata, 32'hCAFEF00D);
        xfer(1'b1, 32'h4C, 32'h55AA55AA, 4'h3, 3'b100, 2, 2'b11, 32'h0, 0, 1'b1);
        chk("decerr_wr", 32'(seen_err), 32'h1);
        chk("decerr_wr_prdata", seen_prdata, 32'h0);

        // Back-to-back transfers.
        n0 = n_start;
        n1 = n_pready;
        xfer(1'b1, 32'h0, 32'h11112222, 4'h5, 3'b000, 1, 2'b00, 32'h0, 0, 1'b0);
        xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 1, 2'b01, 32'h87654321, 0, 1'b0);
        chk("b2b_nstart", n_start - n0, 32'd2);
        chk("b2b_npready", n_pready - n1, 32'd2);
        chk("b2b_addr", seen_addr, 32'h4);
        chk("b2b_prdata", seen_prdata, 32'h87654321);

        // psel with penable already high in idle, plus a completion pulse in idle.
        n0 = n_start;
        n1 = n_pready;
        bus_if.psel    = 1'b1;
        bus_if.penable = 1'b1;
        bus_if.pwrite  = 1'b1;
        bus_if.paddr   = 32'h99;
        step();
        bus_if.done_write = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        chk("proto_nstart", n_start - n0, 32'd0);
        chk("proto_npready", n_pready - n1, 32'd0);

        // Reset while waiting for the engine, then a late done_write.
        s = cyc;
        expect_start(s + 1, 1'b1, 32'hC, 32'hA5A5A5A5, 4'hF, 3'b000);
        bus_if.psel    = 1'b1;
        bus_if.penable = 1'b0;
        bus_if.pwrite  = 1'b1;
        bus_if.paddr   = 32'hC;
        bus_if.pwdata  = 32'hA5A5A5A5;
        bus_if.pstrb   = 4'hF;
        bus_if.pprot   = 3'b000;
        step();
        bus_if.penable = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        step();
        step();
        rst = 1'b0;
        idle_inputs();
        n0 = n_start;
        n1 = n_pready;
        step();
        bus_if.done_write = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        chk("rst_nstart", n_start - n0, 32'd0);
        chk("rst_npready", n_pready - n1, 32'd0);
        xfer(1'b1, 32'h8, 32'h01020304, 4'hF, 3'b011, 2, 2'b00, 32'h0, 0, 1'b0);
        chk("post_rst_addr", seen_addr, 32'h8);
        chk("post_rst_err", 32'(seen_err), 32'h0);

`ifdef APB_TIMEOUT_EN
        // Unanswered read times out; the next write waits for the orphan response.
        xfer(1'b0, 32'h50, 32'h0, 4'h0, 3'b000, 0, 2'b00, 32'h0, 0, 1'b0);
        chk("tout_err", 32'(seen_err), 32'h1);
        chk("tout_prdata", seen_prdata, 32'h0);
        n0 = n_start;
        n1 = n_pready;
        xfer(1'b1, 32'h54, 32'h77778888, 4'hC, 3'b000, 2, 2'b00, 32'h0, 5, 1'b0);
        chk("orphan_nstart", n_start - n0, 32'd1);
        chk("orphan_npready", n_pready - n1, 32'd1);
        chk("orphan_addr", seen_addr, 32'h54);
        chk("orphan_err", 32'(seen_err), 32'h0);
`endif

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_cmd_slave.md
Name: apb_cmd_slave

Overview:
- APB4 slave front end of the APB-to-AXI-Lite bridge; sits directly upstream of the AXI-Lite master engine.
- Converts each APB transfer into a one-cycle start_write/start_read command with latched address, data, prot and byte enables.
- Holds the APB access phase (PREADY low) until the engine reports completion, then returns PRDATA/PSLVERR.
- Exactly one outstanding command at a time.

Parameters:
- AW_APB, 32, APB/AXI address width (paddr, address)
- DW_APB, 32, data width; multiple of 8 (pwdata, prdata, write_data, read_data)
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with APB_TIMEOUT_EN; must be ≥2

Ports:
- axi_clk  in  1  single clock for the APB and command sides
- sys_areset  in  1  asynchronous, active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  AW_APB  APB address
- pwdata  in  DW_APB  APB write data
- pprot  in  3  APB protection
- pstrb  in  DW_APB/8  APB write strobes
- pready  out  1  access-phase completion
- prdata  out  DW_APB  read data
- pslverr  out  1  transfer error
- start_write  out  1  one-cycle write command pulse to the engine
- start_read  out  1  one-cycle read command pulse to the engine
- address  out  AW_APB  latched command address
- write_data  out  DW_APB  latched write data
- prot  out  3  latched pprot
- be  out  DW_APB/8  latched pstrb on writes; all zeros on reads
- resp  in  2  engine response, valid in the cycle done_write or read_data_valid is high
- read_data  in  DW_APB  engine read data, valid with read_data_valid
- read_data_valid  in  1  one-cycle read completion pulse
- done_write  in  1  one-cycle write completion pulse

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE
  - pready, pslverr, start_write, start_read = 0
  - prdata, address, write_data, prot, be = 0
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RESP, DONE.
- IDLE:
  - On psel & ~penable (setup phase), latch paddr → address, pwdata → write_data, pprot → prot.
  - Latch be: pstrb if pwrite, else all zeros. Latch pwrite internally. Go to ISSUE.
- ISSUE (exactly one cycle):
  - start_write = latched pwrite; start_read = ~latched pwrite; go to WAIT_RESP.
  - Setup-to-command latency is 1 cycle; the pulse is 1 cycle wide.
- WAIT_RESP:
  - pready = 0.
  - Write: on done_write, capture resp.
  - Read: on read_data_valid, capture resp and read_data → prdata.
  - After the capture, go to DONE.
  - A completion pulse of the wrong type (e.g. read_data_valid during a write) is ignored.
- DONE (one cycle):
  - pready = 1; pslverr = (captured resp == 2'b10 SLVERR or 2'b11 DECERR).
  - prdata holds the captured value for reads; it is cleared to 0 on writes.
  - Go to IDLE next cycle; pready and pslverr return to 0.
- Minimum APB transfer: setup + 3 access cycles plus engine latency (completion pulse → pready = 1 cycle).
- In IDLE, done_write/read_data_valid are ignored, and psel with penable already high is ignored (protocol error; no command is issued).
- If psel drops while in ISSUE/WAIT_RESP/DONE (master abort), the command still completes internally and pready still pulses; the APB side disregards it.
- Back-to-back transfers: a setup phase in the cycle after DONE is accepted normally.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; any engine completion that arrives later in IDLE is discarded.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to WAIT_RESP and incremented each WAIT_RESP cycle.
  - On reaching TIMEOUT_CYCLES, go to DONE with pslverr = 1 and prdata = 0, and set an orphan flag.
  - While the orphan flag is set, the first done_write/read_data_valid is consumed and clears the flag without affecting any APB transfer.
  - A new command is not issued (ISSUE is deferred, pready stays 0) until the orphan flag clears.
- Undefined: no counter and no orphan flag; WAIT_RESP waits indefinitely.

Test Plan:
- Write: paddr = 0x40, pwdata = 0xDEADBEEF, pstrb = 0xF, pprot = 3'b010; done_write with resp = 00 three cycles after start_write → start_write is a single pulse with address = 0x40, write_data = 0xDEADBEEF, be = 0xF, prot = 3'b010; pready = 1 one cycle after done_write; pslverr = 0.
- Read: paddr = 0x44; read_data_valid with read_data = 0x12345678, resp = 00 → start_read is one pulse with be = 0; prdata = 0x12345678 with pready; pslverr = 0.
- Error: read with resp = 2'b10, then write with resp = 2'b11 → pslverr = 1 on both pready cycles; prdata = 0 on the write.
- Back-to-back: write to 0x0, then read from 0x4 in the next setup cycle after pready → two separate command pulses, each with the correct address; no overlap.
- Reset: assert sys_areset while in WAIT_RESP, release, then issue done_write → pready stays 0 and there is no start pulse; the next transfer to 0x8 completes normally.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES = 16: read with no response → pready and pslverr = 1 after 16 wait cycles, prdata = 0. A following write is held until a late read_data_valid arrives; that pulse is discarded, then the write issues.
